// File: rtl/uart_console_pkg.sv
// Shared types and constants for the UART console monitor.
package uart_console_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } rx_state_e;

  localparam logic [7:0] LINE_CHAR_DEFAULT = 8'h0A;

  // Wide enough to hold 0..depth inclusive.
  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/uart_console_fifo.sv
// First-word fall-through byte FIFO; rdata shows the head combinationally and reads 0 while empty.
module uart_console_fifo
  import uart_console_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           push,
  input  logic [7:0]                     wdata,
  input  logic                           pop,
  output logic [7:0]                     rdata,
  output logic                           empty,
  output logic                           full,
  output logic [count_width(DEPTH)-1:0]  count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = count_width(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // A pop while full frees the slot the simultaneous push needs.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign rdata = empty ? 8'h00 : mem[rd_ptr];

endmodule

// File: rtl/uart_console_monitor.sv
// 8N1 receive sink for the SoC console: deserializer, byte FIFO, line tracking, sticky errors.
//   state     | meaning
//   IDLE      | line idle, waiting for a falling edge
//   START     | half-bit wait, confirm start bit is still low
//   DATA      | sample 8 data bits LSB-first, one per bit period
//   STOP      | sample stop bit; push byte or flag framing error
//   WAIT_IDLE | break/low line after bad stop, wait for rx high
module uart_console_monitor
  import uart_console_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 16,
  parameter int         FIFO_DEPTH   = 64,
  parameter logic [7:0] LINE_CHAR    = LINE_CHAR_DEFAULT
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                rx,
  input  logic                                rd_en,
  output logic [7:0]                          rd_data,
  output logic                                empty,
  output logic                                full,
  output logic [count_width(FIFO_DEPTH)-1:0]  count,
  output logic                                line_ready,
  output logic                                frame_error,
  output logic                                overflow,
  input  logic                                clr_err
);

  localparam int              TW        = $clog2(CLKS_PER_BIT);
  localparam int              CW        = count_width(FIFO_DEPTH);
  localparam logic [TW-1:0]   HALF_LOAD = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0]   FULL_LOAD = TW'(CLKS_PER_BIT - 1);

  logic          rx_meta, rx_sync, rx_prev;
  rx_state_e     state, state_n;
  logic [TW-1:0] timer, timer_n;
  logic [2:0]    bit_idx, bit_idx_n;
  logic [7:0]    shreg, shreg_n;
  logic          push, ferr_set, tc;
  logic          pop_ok, push_ok, ovf_set;
  logic          line_inc, line_dec;
  logic [CW-1:0] line_cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      timer   <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      state   <= state_n;
      timer   <= timer_n;
      bit_idx <= bit_idx_n;
      shreg   <= shreg_n;
    end
  end

  // Timer counts down from load-1 so expiry lands exactly load cycles later.
  assign tc = (timer == '0);

  always_comb begin
    state_n   = state;
    timer_n   = tc ? timer : timer - 1'b1;
    bit_idx_n = bit_idx;
    shreg_n   = shreg;
    push      = 1'b0;
    ferr_set  = 1'b0;
    case (state)
      IDLE: begin
        if (rx_prev && !rx_sync) begin
          timer_n = HALF_LOAD;
          state_n = START;
        end
      end
      START: begin
        if (tc) begin
          if (!rx_sync) begin
            timer_n   = FULL_LOAD;
            bit_idx_n = '0;
            state_n   = DATA;
          end else begin
            state_n = IDLE;
          end
        end
      end
      DATA: begin
        if (tc) begin
          shreg_n   = {rx_sync, shreg[7:1]};
          timer_n   = FULL_LOAD;
          bit_idx_n = bit_idx + 1'b1;
          if (bit_idx == 3'd7) state_n = STOP;
        end
      end
      STOP: begin
        if (tc) begin
          if (rx_sync) begin
            push    = 1'b1;
            state_n = IDLE;
          end else begin
            ferr_set = 1'b1;
            state_n  = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        if (rx_sync) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  uart_console_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .wdata (shreg),
    .pop   (rd_en),
    .rdata (rd_data),
    .empty (empty),
    .full  (full),
    .count (count)
  );

  // Mirrors the FIFO's accept rules so dropped bytes never reach the line count.
  assign pop_ok   = rd_en && !empty;
  assign push_ok  = push && (!full || pop_ok);
  assign ovf_set  = push && full && !pop_ok;
  assign line_inc = push_ok && (shreg == LINE_CHAR);
  assign line_dec = pop_ok && (rd_data == LINE_CHAR);

  always_ff @(posedge clock) begin
    if (reset) begin
      line_cnt    <= '0;
      frame_error <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      case ({line_inc, line_dec})
        2'b10:   line_cnt <= line_cnt + 1'b1;
        2'b01:   line_cnt <= line_cnt - 1'b1;
        default: line_cnt <= line_cnt;
      endcase
      if (clr_err) begin
        frame_error <= 1'b0;
        overflow    <= 1'b0;
      end else begin
        if (ferr_set) frame_error <= 1'b1;
        if (ovf_set)  overflow    <= 1'b1;
      end
    end
  end

  assign line_ready = (line_cnt != '0);

endmodule
